serial_pair_serializer: RTL and testbench
=========================================

SERIAL_PAIR_SERIALIZER -- requirements
Module: serial_pair_serializer

Interface
REQ-001 Parameter: WIDTH, 8, word width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  word pair offered.
REQ-005 Port: in_ready  output  1  word pair accepted this cycle if in_valid also high.
REQ-006 Port: in_a  input  WIDTH  operand A word.
REQ-007 Port: in_b  input  WIDTH  operand B word.
REQ-008 Port: abort  input  1  synchronous frame cancel.
REQ-009 Port: out_restart  output  1  one-cycle pulse preceding each frame; intended to drive the rst of a downstream serial comparator.
REQ-010 Port: out_valid  output  1  out_a/out_b carry a frame bit this cycle.
REQ-011 Port: out_a  output  1  current bit of A.
REQ-012 Port: out_b  output  1  current bit of B.
REQ-013 Port: out_first  output  1  first bit of frame.
REQ-014 Port: out_last  output  1  last bit of frame.

Function
REQ-015 FSM SHALL have states IDLE, START, SHIFT.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, capture in_a/in_b into shift registers and go to START.
REQ-017 START: exactly one cycle; out_restart=1, out_valid=0, in_ready=0; bit counter loaded to WIDTH-1; next state SHIFT.
REQ-018 SHIFT: out_valid=1; out_a/out_b = MSB of the A/B shift registers; registers shift toward the MSB by one bit per cycle; counter decrements by one per cycle.
REQ-019 out_first=1 only in SHIFT with counter==WIDTH-1; out_last=1 only in SHIFT with counter==0; for WIDTH=1 both SHALL be high in the same cycle.
REQ-020 in_ready=1 in SHIFT only when counter==0; an accept there SHALL go to START (back-to-back frames, no idle cycle); otherwise SHIFT with counter==0 SHALL go to IDLE.
REQ-021 Frame latency: first bit on out_a/out_b 2 cycles after the accepting edge; throughput WIDTH+1 cycles per word pair.
REQ-022 out_a, out_b, out_first, out_last SHALL be 0 whenever out_valid=0; out_restart=0 outside START.
REQ-023 abort high in START or SHIFT SHALL return the FSM to IDLE at the next edge; outputs in that cycle are as defined by the current state; abort has priority over a simultaneous accept, and in_ready SHALL be 0 while abort=1.
REQ-024 abort in IDLE SHALL have no effect other than forcing in_ready=0.
REQ-025 Counter width SHALL be max(1, $clog2(WIDTH)) bits; counter SHALL never wrap below 0.
REQ-026 in_a/in_b changes after acceptance SHALL not affect the frame in flight.

Reset
REQ-027 rst high SHALL force state IDLE, counter 0, shift registers 0 at the next edge, regardless of state or abort.
REQ-028 While rst is high, in_ready, out_valid, out_restart, out_a, out_b, out_first, out_last SHALL all be 0; in_ready returns to 1 the first cycle after rst deasserts.
REQ-029 rst mid-frame SHALL discard the frame; no out_last is emitted for it.

Configuration
REQ-030 Macro SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN: when defined, SHIFT emits bit 0 first and shift registers move toward the LSB; when undefined, bit WIDTH-1 is emitted first (MSB-first); handshake, framing, and timing are identical in both builds.

Verification
REQ-031 WIDTH=8, A=0xA5, B=0x5A accepted at cycle 0 -> out_restart at cycle 1; cycles 2..9 out_a=1,0,1,0,0,1,0,1 and out_b=0,1,0,1,1,0,1,0; out_first at cycle 2, out_last at cycle 9.
REQ-032 Two pairs (0x01,0x02) then (0xFF,0xFF) held valid -> second accepted at cycle 9 (out_last cycle), out_restart at cycle 10, second frame bits in cycles 11..18, no gap.
REQ-033 abort at the 4th SHIFT cycle of a frame -> out_valid=0 next cycle, state IDLE, in_ready=1 the following cycle, no out_last.
REQ-034 rst at the 3rd SHIFT cycle with in_valid=1 -> all outputs 0 while rst high, no accept during rst, next frame starts cleanly with out_restart.
REQ-035 Build with SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN, A=0x01, B=0x80 -> out_a=1 then seven 0s; out_b=seven 0s then 1.
REQ-036 WIDTH=1, A=1, B=0 -> single SHIFT cycle with out_first=out_last=1, out_a=1, out_b=0; back-to-back period 2 cycles.

Source files
------------

// File: rtl/serial_pair_serializer.sv
// Serializes an A/B word pair into a framed bit stream behind a restart pulse.
// Define SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN for LSB-first emission.
module serial_pair_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             abort,
    output logic             out_restart,
    output logic             out_valid,
    output logic             out_a,
    output logic             out_b,
    output logic             out_first,
    output logic             out_last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        SHIFT
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] sa, sb, sa_nx, sb_nx;
    logic last_bit, accept, bit_a, bit_b;

`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
    assign bit_a = sa[0];
    assign bit_b = sb[0];
`else
    assign bit_a = sa[WIDTH-1];
    assign bit_b = sb[WIDTH-1];
`endif

    assign last_bit = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            sa    <= sa_nx;
            sb    <= sb_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        sa_nx       = sa;
        sb_nx       = sb;
        in_ready    = 1'b0;
        out_restart = 1'b0;
        out_valid   = 1'b0;
        out_a       = 1'b0;
        out_b       = 1'b0;
        out_first   = 1'b0;
        out_last    = 1'b0;

        unique case (state)
            IDLE: in_ready = !abort;
            START: out_restart = 1'b1;
            SHIFT: begin
                out_valid = 1'b1;
                out_a     = bit_a;
                out_b     = bit_b;
                out_first = (cnt == TOP);
                out_last  = last_bit;
                in_ready  = last_bit && !abort;
            end
            default: ;
        endcase

        // Reset masks every output, including the combinational ready.
        if (rst) begin
            in_ready    = 1'b0;
            out_restart = 1'b0;
            out_valid   = 1'b0;
            out_a       = 1'b0;
            out_b       = 1'b0;
            out_first   = 1'b0;
            out_last    = 1'b0;
        end

        accept = in_valid && in_ready;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = START;
                    sa_nx    = in_a;
                    sb_nx    = in_b;
                end
            end
            START: begin
                state_nx = SHIFT;
                cnt_nx   = TOP;
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        state_nx = START;
                        sa_nx    = in_a;
                        sb_nx    = in_b;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - 1'b1;
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
                    sa_nx = sa >> 1;
                    sb_nx = sb >> 1;
`else
                    sa_nx = sa << 1;
                    sb_nx = sb << 1;
`endif
                end
            end
            default: state_nx = IDLE;
        endcase

        if (abort && state != IDLE)
            state_nx = IDLE;
    end

endmodule

// File: tb/tb_serial_pair_serializer.sv
// Directed plus randomized bench for serial_pair_serializer against a
// cycle-position reference model of the framing rules.
module tb_serial_pair_serializer;

    localparam int W = 8;
`ifdef SERIAL_PAIR_SERIALIZER_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, in_valid, abort;
    logic [W-1:0] in_a, in_b;
    logic in_ready, out_restart, out_valid, out_a, out_b, out_first, out_last;

    serial_pair_serializer #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .abort(abort),
        .out_restart(out_restart),
        .out_valid(out_valid),
        .out_a(out_a),
        .out_b(out_b),
        .out_first(out_first),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    // pos: 0 idle, 1 restart cycle, 2..W+1 frame bit (pos-2)
    int pos = 0;
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;

    task automatic step(input logic r, input logic v, input logic ab,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input string tag);
        logic [6:0] exp, got;
        logic er;
        int i, bi;
        rst = r;
        in_valid = v;
        abort = ab;
        in_a = a;
        in_b = b;
        @(negedge clk);
        er = !r && !ab && (pos == 0 || pos == W + 1);
        exp = '0;
        if (!r) begin
            exp[6] = er;
            exp[5] = (pos == 1);
            if (pos >= 2) begin
                i = pos - 2;
                bi = LSB ? i : W - 1 - i;
                exp[4] = 1'b1;
                exp[3] = ma[bi];
                exp[2] = mb[bi];
                exp[1] = (i == 0);
                exp[0] = (i == W - 1);
            end
        end
        got = {in_ready, out_restart, out_valid, out_a, out_b,
               out_first, out_last};
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d rdy/rs/v/a/b/f/l got=%b exp=%b",
                   tag, cyc, got, exp);
        end
        if (r) begin
            pos = 0;
        end else if (ab && pos != 0) begin
            pos = 0;
        end else if (v && er) begin
            pos = 1;
            ma = a;
            mb = b;
        end else if (pos == W + 1) begin
            pos = 0;
        end else if (pos > 0) begin
            pos++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        abort = 1'b0;
        in_a = '0;
        in_b = '0;

        step(1, 0, 0, '0, '0, "reset");
        step(1, 1, 0, 8'h33, 8'h44, "reset_valid");
        step(0, 0, 0, '0, '0, "idle");

        step(0, 1, 0, 8'hA5, 8'h5A, "a5_accept");
        for (int k = 0; k < 10; k++)
            step(0, 0, 0, rnd(), rnd(), "a5_frame");

        step(0, 1, 0, 8'h01, 8'h02, "b2b_first");
        for (int k = 0; k < 9; k++)
            step(0, 1, 0, 8'hFF, 8'hFF, "b2b_hold");
        for (int k = 0; k < 10; k++)
            step(0, 0, 0, rnd(), rnd(), "b2b_second");

        step(0, 1, 0, 8'hC3, 8'h3C, "abort_accept");
        for (int k = 0; k < 4; k++)
            step(0, 0, 0, rnd(), rnd(), "abort_pre");
        step(0, 1, 1, 8'h11, 8'h22, "abort_hit");
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, rnd(), rnd(), "abort_post");

        step(0, 1, 0, 8'h96, 8'h69, "rst_accept");
        for (int k = 0; k < 3; k++)
            step(0, 0, 0, rnd(), rnd(), "rst_pre");
        step(1, 1, 0, 8'h77, 8'h88, "rst_mid");
        step(1, 1, 0, 8'h77, 8'h88, "rst_mid2");
        step(0, 1, 0, 8'hE1, 8'h1E, "rst_restart");
        for (int k = 0; k < 10; k++)
            step(0, 0, 0, rnd(), rnd(), "rst_frame");

        step(0, 1, 1, 8'h55, 8'hAA, "idle_abort");
        step(0, 0, 0, '0, '0, "idle_after_abort");

        for (int k = 0; k < 600; k++)
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 11) == 0),
                 rnd(), rnd(), "random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
